// File: rtl/rfft_4pt_core_if.sv
// rfft_4pt_core_if: load data, bank read-back, operand/routing selects, twiddle and addresses of rfft_4pt_core.
interface rfft_4pt_core_if #(
   parameter int ADDR_BIT = 3,
   parameter int DATA_BIT = 16
);
   logic signed [DATA_BIT-1:0] in0, in1, in2, in3;
   logic signed [DATA_BIT-1:0] mem0, mem1, mem2, mem3;
   logic                       m0, m11, m14;
   logic [1:0]                 m12, m13;
   logic                       m21, m22, m23, m24;
   logic signed [DATA_BIT-1:0] w_r, w_i;
   logic                       bypass_en;
   logic [4*ADDR_BIT-1:0]      addr_read, addr_write;
   modport master (
      output in0, in1, in2, in3, m0, m11, m12, m13, m14, m21, m22, m23, m24,
      output w_r, w_i, bypass_en, addr_read, addr_write,
      input  mem0, mem1, mem2, mem3
   );
   modport slave (
      input  in0, in1, in2, in3, m0, m11, m12, m13, m14, m21, m22, m23, m24,
      input  w_r, w_i, bypass_en, addr_read, addr_write,
      output mem0, mem1, mem2, mem3
   );
endinterface

// File: rtl/rfft_4pt_core.sv
// rfft_4pt_core: four-bank in-place radix-2 butterfly datapath with optional twiddle multiply.
// Define RFFT_4PT_SAT_EN to saturate butterfly outputs; otherwise they wrap to DATA_BIT bits.
module rfft_4pt_core #(
   parameter int ADDR_BIT = 3,
   parameter int DATA_BIT = 16
) (
   input logic            clk,
   input logic            rst_n,
   rfft_4pt_core_if.slave io
);
   localparam int W = DATA_BIT;
   localparam int D = 1 << ADDR_BIT;
   logic signed [W-1:0]   rd [4];
   logic [W-1:0]          bank_d [4];
   logic [W-1:0]          nar [4];
   logic signed [W-1:0]   ar, ai, br, bi;
   logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [2*W:0]   s_r, s_i;
   logic signed [W+1:0]   ar_x, ai_x, tr_x, ti_x;
   logic signed [W+1:0]   res [4];
   logic                  unused_bits;
   always_comb begin
      ar   = io.m11 ? rd[1] : rd[0];
      ai   = (io.m12 == 2'd3) ? '0 : rd[io.m12];
      br   = (io.m13 == 2'd3) ? '0 : rd[io.m13 + 2'd1];
      bi   = io.m14 ? rd[3] : rd[2];
      p_rr = (2*W)'(br) * (2*W)'(io.w_r);
      p_ii = (2*W)'(bi) * (2*W)'(io.w_i);
      p_ri = (2*W)'(br) * (2*W)'(io.w_i);
      p_ir = (2*W)'(bi) * (2*W)'(io.w_r);
      s_r  = (2*W+1)'(p_rr) - (2*W+1)'(p_ii);
      s_i  = (2*W+1)'(p_ri) + (2*W+1)'(p_ir);
      // taking bits [2W-1:W-1] is the >>> (W-1) followed by truncation to W+1 bits
      tr_x = io.bypass_en ? (W+2)'(br) : (W+2)'($signed(s_r[2*W-1:W-1]));
      ti_x = io.bypass_en ? (W+2)'(bi) : (W+2)'($signed(s_i[2*W-1:W-1]));
      ar_x = (W+2)'(ar);
      ai_x = (W+2)'(ai);
      res[0] = (ar_x + tr_x) >>> 1;
      res[1] = (ai_x + ti_x) >>> 1;
      res[2] = (ar_x - tr_x) >>> 1;
      res[3] = (ai_x - ti_x) >>> 1;
      bank_d[0] = io.m0 ? (io.m21 ? nar[2] : nar[0]) : io.in0;
      bank_d[1] = io.m0 ? (io.m22 ? nar[3] : nar[1]) : io.in1;
      bank_d[2] = io.m0 ? (io.m23 ? nar[2] : nar[0]) : io.in2;
      bank_d[3] = io.m0 ? (io.m24 ? nar[3] : nar[1]) : io.in3;
   end
   assign unused_bits = ^{s_r[2*W], s_r[W-2:0], s_i[2*W], s_i[W-2:0],
                          res[0][W+1:W], res[1][W+1:W], res[2][W+1:W], res[3][W+1:W]};
   for (genvar g = 0; g < 4; g++) begin : g_bank
      logic [W-1:0] bank_q [D];
`ifdef RFFT_4PT_SAT_EN
      assign nar[g] = (res[g][W+1:W-1] == 3'b000 || res[g][W+1:W-1] == 3'b111) ? res[g][W-1:0]
                    : {res[g][W+1], {(W-1){~res[g][W+1]}}};
`else
      assign nar[g] = res[g][W-1:0];
`endif
      assign rd[g] = bank_q[io.addr_read[g*ADDR_BIT +: ADDR_BIT]];
      always_ff @(posedge clk) begin
         if (!rst_n) bank_q <= '{default: '0};
         else bank_q[io.addr_write[g*ADDR_BIT +: ADDR_BIT]] <= bank_d[g];
      end
   end
   assign io.mem0 = rd[0];
   assign io.mem1 = rd[1];
   assign io.mem2 = rd[2];
   assign io.mem3 = rd[3];
endmodule

// File: tb/tb_rfft_4pt_core.sv
// tb_rfft_4pt_core: directed table-driven checks of load, butterfly, routing, wrap/saturation and reset.
module tb_rfft_4pt_core;
   localparam int AB = 3;
   localparam int DB = 16;
`ifdef RFFT_4PT_SAT_EN
   localparam logic [15:0] OV_NEG = 16'h8000, OV_POS = 16'h7FFF;
`else
   localparam logic [15:0] OV_NEG = 16'h4000, OV_POS = 16'hBFFF;
`endif
   localparam logic [5:0] DS = {1'b0, 2'd1, 2'd1, 1'b1};
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   rfft_4pt_core_if #(.ADDR_BIT(AB), .DATA_BIT(DB)) io ();
   rfft_4pt_core #(.ADDR_BIT(AB), .DATA_BIT(DB)) dut (.clk(clk), .rst_n(rst_n), .io(io));
   typedef struct {
      logic [0:3][15:0] ld;
      logic [5:0]       sel;
      logic [3:0]       m2;
      logic             byp;
      logic [15:0]      wr, wi;
      logic [0:3][15:0] ex;
   } vec_t;
   vec_t vecs [11];
   function automatic vec_t mk(input logic [0:3][15:0] ld, input logic [5:0] sel, input logic [3:0] m2,
                               input logic byp, input logic [15:0] wr, wi, input logic [0:3][15:0] ex);
      vec_t v;
      v.ld = ld; v.sel = sel; v.m2 = m2; v.byp = byp; v.wr = wr; v.wi = wi; v.ex = ex;
      return v;
   endfunction
   function automatic logic [11:0] rep(input int a);
      return {4{3'(a)}};
   endfunction
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask
   task automatic mem_chk(input string name, input logic [0:3][15:0] exp);
      logic [0:3][15:0] m;
      m = {io.mem0, io.mem1, io.mem2, io.mem3};
      for (int k = 0; k < 4; k++) chk($sformatf("%s_bank%0d", name, k), m[k], exp[k]);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic set_in(input logic [0:3][15:0] d);
      io.in0 = d[0]; io.in1 = d[1]; io.in2 = d[2]; io.in3 = d[3];
   endtask
   task automatic load(input int a, input logic [0:3][15:0] d);
      io.m0 = 1'b0;
      io.addr_write = rep(a);
      set_in(d);
      tick;
   endtask
   initial begin
      logic [0:3][15:0] std;
      std = {16'h1000, 16'h2000, 16'h0800, 16'h0400};
      vecs[0]  = mk(std, DS, 4'b1100, 1'b1, 16'h0000, 16'h0000, {16'h0C00, 16'h1200, 16'h0400, 16'h0E00});
      vecs[1]  = mk(std, DS, 4'b1100, 1'b0, 16'h0000, 16'h8000, {16'h0A00, 16'h0C00, 16'h0600, 16'h1400});
      vecs[2]  = mk(std, DS, 4'b0011, 1'b1, 16'h0000, 16'h0000, {16'h0400, 16'h0E00, 16'h0C00, 16'h1200});
      vecs[3]  = mk({16'h2000, 16'h1000, 16'h0400, 16'h0800}, {1'b1, 2'd0, 2'd2, 1'b0}, 4'b1100, 1'b1,
                    16'h0000, 16'h0000, {16'h0C00, 16'h1200, 16'h0400, 16'h0E00});
      vecs[4]  = mk(std, DS, 4'b1100, 1'b0, 16'h7FFF, 16'h0000, {16'h0BFF, 16'h11FF, 16'h0400, 16'h0E00});
      vecs[5]  = mk(std, {1'b0, 2'd3, 2'd3, 1'b1}, 4'b1100, 1'b1, 16'h0000, 16'h0000,
                    {16'h0800, 16'h0200, 16'h0800, 16'hFE00});
      vecs[6]  = mk(std, {1'b0, 2'd2, 2'd0, 1'b0}, 4'b0110, 1'b1, 16'h0000, 16'h0000,
                    {16'h1800, 16'h0000, 16'hF800, 16'h0800});
      vecs[7]  = mk({16'h0001, 16'hFFFF, 16'h0000, 16'h0000}, DS, 4'b1100, 1'b1, 16'h0000, 16'h0000,
                    {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF});
      vecs[8]  = mk({16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000}, DS, 4'b1100, 1'b1, 16'h0000, 16'h0000,
                    {16'h7FFF, 16'h8000, 16'h0000, 16'h0000});
      vecs[9]  = mk({16'h8000, 16'h0000, 16'h7FFF, 16'h8000}, DS, 4'b1100, 1'b0, 16'h8000, 16'h8000,
                    {OV_NEG, 16'h0000, 16'h3FFF, 16'hFFFF});
      vecs[10] = mk({16'h7FFF, 16'h0000, 16'h8000, 16'h7FFF}, DS, 4'b1100, 1'b0, 16'h8000, 16'h8000,
                    {OV_POS, 16'h0000, 16'hC000, 16'hFFFF});
      set_in('0);
      io.m0 = 1'b0;
      {io.m11, io.m12, io.m13, io.m14} = DS;
      {io.m24, io.m23, io.m22, io.m21} = 4'b1100;
      io.w_r = '0; io.w_i = '0; io.bypass_en = 1'b1;
      io.addr_read = '0; io.addr_write = '0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         io.addr_read = rep(a);
         #1 mem_chk($sformatf("reset_a%0d", a), '0);
      end
      for (int i = 0; i < 11; i++) begin
         load(i % 8, vecs[i].ld);
         io.addr_read = rep(i % 8);
         #1 mem_chk($sformatf("load_v%0d", i), vecs[i].ld);
         {io.m11, io.m12, io.m13, io.m14} = vecs[i].sel;
         {io.m24, io.m23, io.m22, io.m21} = vecs[i].m2;
         io.bypass_en = vecs[i].byp;
         io.w_r = vecs[i].wr;
         io.w_i = vecs[i].wi;
         io.m0 = 1'b1;
         io.addr_write = rep(i % 8);
         tick;
         mem_chk($sformatf("bfly_v%0d", i), vecs[i].ex);
      end
      load(5, {16'h0101, 16'h0202, 16'h0303, 16'h0404});
      set_in({16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D});
      io.addr_read = rep(5);
      #1 mem_chk("rw_same_pre", {16'h0101, 16'h0202, 16'h0303, 16'h0404});
      tick;
      mem_chk("rw_same_post", {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D});
      load(1, {16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00});
      io.addr_write = {3'd4, 3'd3, 3'd2, 3'd1};
      set_in({16'h1111, 16'h2222, 16'h3333, 16'h4444});
      tick;
      io.addr_read = {3'd4, 3'd3, 3'd2, 3'd1};
      #1 mem_chk("pack_own", {16'h1111, 16'h2222, 16'h3333, 16'h4444});
      io.addr_read = rep(1);
      #1 mem_chk("pack_a1", {16'h1111, 16'h0B00, 16'h0C00, 16'h0D00});
      io.m0 = 1'b0;
      io.addr_write = rep(1);
      set_in({4{16'h5555}});
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      io.addr_read = rep(1);
      #1 mem_chk("rst_override", '0);
      io.addr_read = rep(4);
      #1 mem_chk("rst_clear_a4", '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
